sd_deserializer: RTL and testbench

Consumes the serial bit stream `sd` produced by the counter/serial-output stage and hunts for a fixed sync pattern. After sync it shifts in one WORD_W-bit data word, MSB first, and presents it on a one-entry valid/ready output register. It also reports lock, overrun and a delivered-frame count to the downstream register/debug logic.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_sync_detect.sv | 48 ++++
 rtl/sd_deserializer.sv | 170 +++++++++++++++++
 tb/tb_sd_deserializer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and defaults for the sd_deserializer slice.
// The optional parity stage is enabled by defining SD_DESER_PARITY_CHECK_EN.
package sd_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sd_state_t;

    localparam int              WORD_W_DEFAULT       = 8;
    localparam int              SYNC_W_DEFAULT       = 4;
    localparam int              CNT_W_DEFAULT        = 16;
    localparam logic [3:0]      SYNC_PATTERN_DEFAULT = 4'b1011;

    // Counter width able to index n distinct values; never narrower than 1 bit.
    function automatic int sd_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sd_sync_detect.sv
// Sync-pattern hunter: shifts sampled bits into sync_sr and flags a match once
// at least SYNC_W bits have been seen since the last clear.
module sd_sync_detect
    import sd_pkg::*;
#(
    parameter int                SYNC_W       = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift_en,
    input  logic sd,
    output logic match
);

    localparam int HC_W = sd_cnt_width(SYNC_W + 1);

    logic [SYNC_W-1:0] sync_sr_reg;
    logic [SYNC_W-1:0] sync_sr_next;
    logic [HC_W-1:0]   hunt_cnt_reg;
    logic [HC_W-1:0]   hunt_cnt_next;

    assign sync_sr_next[0] = sd;
    generate
        for (genvar gi = 1; gi < SYNC_W; gi++) begin : g_sync_shift
            assign sync_sr_next[gi] = sync_sr_reg[gi-1];
        end
    endgenerate

    always_comb begin
        hunt_cnt_next = (hunt_cnt_reg == HC_W'(SYNC_W)) ? hunt_cnt_reg : hunt_cnt_reg + 1'b1;
        // The bit-count qualifier stops post-reset zeros from aliasing a pattern.
        match = shift_en && (sync_sr_next == SYNC_PATTERN)
                && ((32'(hunt_cnt_reg) + 32'd1) >= 32'(SYNC_W));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sync_sr_reg  <= '0;
            hunt_cnt_reg <= '0;
        end else if (shift_en) begin
            sync_sr_reg  <= sync_sr_next;
            hunt_cnt_reg <= hunt_cnt_next;
        end
    end

endmodule

// File: rtl/sd_deserializer.sv
// Serial-to-word receiver: hunts for a sync word, shifts in one MSB-first word and
// hands it out through a one-entry valid/ready register. Parity: SD_DESER_PARITY_CHECK_EN.
module sd_deserializer
    import sd_pkg::*;
#(
    parameter int                WORD_W       = WORD_W_DEFAULT,
    parameter int                SYNC_W       = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
    parameter int                CNT_W        = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sd,
    input  logic              sd_valid,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              sync_lock,
    output logic              overrun,
    output logic              parity_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BC_W = sd_cnt_width(WORD_W);

    sd_state_t         state_reg, state_next;
    logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0] data_sr_reg, data_sr_next;
    logic [WORD_W-1:0] word;
    logic              deliver;
    logic              load;
    logic              sync_match;
    logic              sync_clear;
    logic              hunt_en;

    logic [WORD_W-1:0] data_out_reg;
    logic              data_valid_reg;
    logic              overrun_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;

    // Hunter is held cleared outside HUNT, so it always restarts from zero.
    assign sync_clear = (state_reg != HUNT);
    assign hunt_en    = sd_valid && (state_reg == HUNT);

    sd_sync_detect #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync_detect (
        .clk      (clk),
        .reset    (reset),
        .clear    (sync_clear),
        .shift_en (hunt_en),
        .sd       (sd),
        .match    (sync_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= HUNT;
            bit_cnt_reg <= '0;
            data_sr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            data_sr_reg <= data_sr_next;
        end
    end

`ifdef SD_DESER_PARITY_CHECK_EN
    logic parity_fail;
`endif

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        data_sr_next = data_sr_reg;
        word         = data_sr_reg;
        deliver      = 1'b0;
`ifdef SD_DESER_PARITY_CHECK_EN
        parity_fail  = 1'b0;
`endif
        case (state_reg)
            HUNT: begin
                if (sync_match) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (sd_valid) begin
                    data_sr_next = {data_sr_reg[WORD_W-2:0], sd};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BC_W'(WORD_W - 1)) begin
`ifdef SD_DESER_PARITY_CHECK_EN
                        state_next = PARITY;
`else
                        state_next = HUNT;
                        deliver    = 1'b1;
                        word       = data_sr_next;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef SD_DESER_PARITY_CHECK_EN
                if (sd_valid) begin
                    state_next = HUNT;
                    if (sd == ^data_sr_reg) begin
                        deliver = 1'b1;
                    end else begin
                        parity_fail = 1'b1;
                    end
                end
`else
                state_next = HUNT;
`endif
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        sync_lock = (state_reg != HUNT);
    end

    // A full register can still take a word when it is being drained on the same edge.
    assign load = deliver && (!data_valid_reg || data_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
        end else if (load) begin
            data_out_reg   <= word;
            data_valid_reg <= 1'b1;
            frame_cnt_reg  <= frame_cnt_reg + 1'b1;
        end else begin
            if (deliver) begin
                overrun_reg <= 1'b1;
            end
            if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

`ifdef SD_DESER_PARITY_CHECK_EN
    logic parity_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_reg <= 1'b0;
        end else if (parity_fail) begin
            parity_err_reg <= 1'b1;
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign overrun    = overrun_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_sd_deserializer.sv
// Directed bench for sd_deserializer; a second instance uses sync pattern 4'b0011.
// Follows SD_DESER_PARITY_CHECK_EN to decide whether frames carry a parity bit.
module tb_sd_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd;
    logic        sd_valid;
    logic        data_ready;

    logic [7:0]  data_out;
    logic        data_valid;
    logic        sync_lock;
    logic        overrun;
    logic        parity_err;
    logic [15:0] frame_cnt;

    logic [7:0]  d2_data_out;
    logic        d2_data_valid;
    logic        d2_sync_lock;
    logic        d2_overrun;
    logic        d2_parity_err;
    logic [15:0] d2_frame_cnt;

    int errors    = 0;
    int checks    = 0;
    int lock_bits = 0;

`ifdef SD_DESER_PARITY_CHECK_EN
    localparam int BODY_BITS = 9;
`else
    localparam int BODY_BITS = 8;
`endif

    always #5 clk = ~clk;

    sd_deserializer #(
        .WORD_W (8), .SYNC_W (4), .SYNC_PATTERN (4'b1011), .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sd         (sd),
        .sd_valid   (sd_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .sync_lock  (sync_lock),
        .overrun    (overrun),
        .parity_err (parity_err),
        .frame_cnt  (frame_cnt)
    );

    sd_deserializer #(
        .WORD_W (8), .SYNC_W (4), .SYNC_PATTERN (4'b0011), .CNT_W (16)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .sd         (sd),
        .sd_valid   (sd_valid),
        .data_out   (d2_data_out),
        .data_valid (d2_data_valid),
        .data_ready (data_ready),
        .sync_lock  (d2_sync_lock),
        .overrun    (d2_overrun),
        .parity_err (d2_parity_err),
        .frame_cnt  (d2_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sd       = b;
        sd_valid = 1'b1;
        if (sync_lock) lock_bits++;
        tick();
        sd_valid = 1'b0;
        sd       = 1'b0;
    endtask

    // Inserts an idle cycle with random sd before every valid bit.
    task automatic send_bit_gap(input logic b);
        sd       = 1'($urandom);
        sd_valid = 1'b0;
        tick();
        send_bit(b);
    endtask

    task automatic send_word(input logic [7:0] w, input logic gap);
        for (int i = 7; i >= 0; i--) begin
            if (gap) send_bit_gap(w[i]);
            else     send_bit(w[i]);
        end
    endtask

    task automatic send_sync(input logic gap);
        logic [3:0] pat;
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            if (gap) send_bit_gap(pat[i]);
            else     send_bit(pat[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic gap);
        send_sync(gap);
        send_word(w, gap);
`ifdef SD_DESER_PARITY_CHECK_EN
        if (gap) send_bit_gap(^w);
        else     send_bit(^w);
`endif
        $display("frame %02h sent: data_out=%02h valid=%0b overrun=%0b cnt=%0d",
                 w, data_out, data_valid, overrun, frame_cnt);
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        sd_valid = 1'b0;
        sd       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check({tag, "_rst_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_rst_lock"},  32'(sync_lock),  32'd0);
        check({tag, "_rst_ovr"},   32'(overrun),    32'd0);
        check({tag, "_rst_cnt"},   32'(frame_cnt),  32'd0);
        check({tag, "_rst_data"},  32'(data_out),   32'd0);
        check({tag, "_rst_perr"},  32'(parity_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; sd = 1'b0; sd_valid = 1'b0; data_ready = 1'b1;

        // 1: continuous frame 0xA5
        do_reset("t1");
        lock_bits = 0;
        send_sync(1'b0);
        check("t1_lock_after_sync", 32'(sync_lock), 32'd1);
        send_word(8'hA5, 1'b0);
`ifdef SD_DESER_PARITY_CHECK_EN
        send_bit(1'b0);
`endif
        check("t1_valid",     32'(data_valid), 32'd1);
        check("t1_data",      32'(data_out),   32'h0A5);
        check("t1_cnt",       32'(frame_cnt),  32'd1);
        check("t1_lock_end",  32'(sync_lock),  32'd0);
        check("t1_lock_bits", 32'(lock_bits),  32'(BODY_BITS));
        tick();
        check("t1_valid_1cyc", 32'(data_valid), 32'd0);
        check("t1_data_hold",  32'(data_out),   32'h0A5);

        // 2: same frame with gaps and garbage on invalid cycles
        do_reset("t2");
        send_frame(8'hA5, 1'b1);
        check("t2_valid", 32'(data_valid), 32'd1);
        check("t2_data",  32'(data_out),   32'h0A5);
        check("t2_cnt",   32'(frame_cnt),  32'd1);

        // 3: back-pressure and overrun
        data_ready = 1'b0;
        do_reset("t3");
        send_frame(8'h3C, 1'b0);
        check("t3_first_valid", 32'(data_valid), 32'd1);
        check("t3_first_ovr",   32'(overrun),    32'd0);
        send_frame(8'h81, 1'b0);
        check("t3_data",  32'(data_out),   32'h03C);
        check("t3_valid", 32'(data_valid), 32'd1);
        check("t3_ovr",   32'(overrun),    32'd1);
        check("t3_cnt",   32'(frame_cnt),  32'd1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("t3_drain_valid", 32'(data_valid), 32'd0);
        check("t3_ovr_sticky",  32'(overrun),    32'd1);
        data_ready = 1'b1;

        // 4: false start 1,0,1,0 before the real sync
        do_reset("t4");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("t4_nolock_1010", 32'(sync_lock), 32'd0);
        send_bit(1'b1);
        check("t4_nolock_0101", 32'(sync_lock), 32'd0);
        send_bit(1'b1);
        check("t4_lock_1011", 32'(sync_lock), 32'd1);
        send_word(8'h5A, 1'b0);
`ifdef SD_DESER_PARITY_CHECK_EN
        send_bit(1'b0);
`endif
        check("t4_data",  32'(data_out),   32'h05A);
        check("t4_valid", 32'(data_valid), 32'd1);

        // 4b: pattern 0011 must not match post-reset zeros plus 1,1
        do_reset("t4b");
        send_bit(1'b1); send_bit(1'b1);
        check("t4b_d2_nolock", 32'(d2_sync_lock), 32'd0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("t4b_d2_lock", 32'(d2_sync_lock), 32'd1);

        // 5: reset in the middle of a frame body
        do_reset("t5");
        send_sync(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("t5_lock_mid", 32'(sync_lock), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_lock_after_rst",  32'(sync_lock),  32'd0);
        check("t5_valid_after_rst", 32'(data_valid), 32'd0);
        send_frame(8'hC3, 1'b0);
        check("t5_data",  32'(data_out),   32'h0C3);
        check("t5_valid", 32'(data_valid), 32'd1);
        check("t5_cnt",   32'(frame_cnt),  32'd1);

        // 6: parity handling
        do_reset("t6");
`ifdef SD_DESER_PARITY_CHECK_EN
        send_sync(1'b0); send_word(8'hA5, 1'b0); send_bit(1'b0);
        check("t6_good_valid", 32'(data_valid), 32'd1);
        check("t6_good_perr",  32'(parity_err), 32'd0);
        check("t6_good_cnt",   32'(frame_cnt),  32'd1);
        tick();
        send_sync(1'b0); send_word(8'hA5, 1'b0); send_bit(1'b1);
        check("t6_bad_valid", 32'(data_valid), 32'd0);
        check("t6_bad_perr",  32'(parity_err), 32'd1);
        check("t6_bad_cnt",   32'(frame_cnt),  32'd1);
        $display("parity frames sent: perr=%0b cnt=%0d", parity_err, frame_cnt);
`else
        send_frame(8'h96, 1'b0);
        check("t6_data", 32'(data_out),   32'h096);
        check("t6_perr", 32'(parity_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
